// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, controller states and request decode helpers
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    // Illegal width code or an access that crosses its natural alignment
    function automatic logic req_bad(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic illegal;
        logic misaligned;
        illegal    = we ? !(f3 == F3_B || f3 == F3_H || f3 == F3_W)
                        : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        misaligned = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
        return illegal || misaligned;
    endfunction

    function automatic logic [3:0] be_of(input logic [2:0] f3, input logic [1:0] a);
        return f3[1:0] == 2'b00 ? 4'b0001 << a :
               f3[1:0] == 2'b01 ? 4'b0011 << a : 4'b1111;
    endfunction

    function automatic logic [31:0] wdata_of(input logic [2:0] f3, input logic [31:0] d);
        return f3[1:0] == 2'b00 ? {4{d[7:0]}} :
               f3[1:0] == 2'b01 ? {2{d[15:0]}} : d;
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed byte/half lane of a read word and extends it
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);

    logic [31:0] sh;

    // Shift the addressed lane down to bit 0, then extend by width code
    always_comb begin
        sh    = word >> {addr, 3'b000};
        value = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
                funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
                funct3 == F3_W  ? word :
                funct3 == F3_BU ? {24'd0, sh[7:0]} :
                funct3 == F3_HU ? {16'd0, sh[15:0]} : 32'd0;
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding RV32I load/store controller to a word bus
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    state_t      state, state_n;
    logic        we_q, err_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] rdata_q, aligned;
    logic        bad, accept;

    assign req_ready = state == S_IDLE;
    assign busy      = state != S_IDLE;
    assign mem_req   = state == S_REQ;
    assign rsp_valid = state == S_RESP;
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
    assign accept    = req_valid && req_ready;
    assign bad       = req_bad(req_we, req_funct3, req_addr[1:0]);

    load_align u_align (
        .word   (mem_rdata),
        .addr   (off_q),
        .funct3 (f3_q),
        .value  (aligned)
    );

    // State register; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next state: errors skip the bus, stores skip the read wait
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (accept) state_n = bad ? S_RESP : S_REQ;
            S_REQ:   if (mem_gnt) state_n = we_q ? S_RESP : S_WAIT;
            S_WAIT:  if (mem_rvalid) state_n = S_RESP;
            default: state_n = S_IDLE;
        endcase
    end

    // Request fields latch on acceptance so the bus sees them stable; load data latches in WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            f3_q      <= 3'd0;
            off_q     <= 2'd0;
            rdata_q   <= 32'd0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
        end else begin
            if (accept) begin
                we_q      <= req_we;
                err_q     <= bad;
                f3_q      <= req_funct3;
                off_q     <= req_addr[1:0];
                rdata_q   <= 32'd0;
                mem_we    <= req_we && !bad;
                mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                mem_be    <= bad ? 4'd0 : be_of(req_funct3, req_addr[1:0]);
                mem_wdata <= (req_we && !bad) ? wdata_of(req_funct3, req_wdata) : 32'd0;
            end
            if (state == S_WAIT && mem_rvalid) rdata_q <= aligned;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed vector table plus grant-stall and mid-transaction reset sequences
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    lsu_ctrl #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Caller sits at a negedge with the DUT idle; returns at the negedge after the response
    task automatic run(input int i, input vec_t v);
        int  n;
        bit  seen;
        string p;
        p = $sformatf("v%0d", i);
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!rsp_valid && n < 20) begin
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            if (mem_req) begin
                if (!seen) begin
                    chk({p, "_addr"}, mem_addr, {v.addr[31:2], 2'b00});
                    chk({p, "_we"}, {31'd0, mem_we}, {31'd0, v.we});
                    if (v.we) begin
                        chk({p, "_be"}, {28'd0, mem_be}, {28'd0, v.exp_be});
                        chk({p, "_wdata"}, mem_wdata, v.exp_wdata);
                    end
                end
                seen = 1'b1;
                mem_gnt = 1'b1;
            end else if (busy) begin
                mem_rvalid = 1'b1;
                mem_rdata = v.rdata;
            end
            @(negedge clk);
            n++;
        end
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        chk({p, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({p, "_latency"}, n, v.lat);
        chk({p, "_bus_used"}, {31'd0, seen}, {31'd0, v.lat != 0});
        chk({p, "_err"}, {31'd0, rsp_err}, {31'd0, v.exp_err});
        chk({p, "_rdata"}, rsp_rdata, v.exp_rdata);
        @(negedge clk);
        chk({p, "_pulse_end"}, {31'd0, rsp_valid}, 32'd0);
        chk({p, "_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        //           we  f3      addr       wdata         rdata         err exp_rdata     be       exp_wdata     lat
        vecs[0]  = '{0, 3'b000, 32'h103, 32'h0,        32'h80FFFF12, 0, 32'hFFFFFF80, 4'h0,    32'h0,        2};
        vecs[1]  = '{0, 3'b101, 32'h102, 32'h0,        32'h80011234, 0, 32'h00008001, 4'h0,    32'h0,        2};
        vecs[2]  = '{0, 3'b001, 32'h102, 32'h0,        32'h80011234, 0, 32'hFFFF8001, 4'h0,    32'h0,        2};
        vecs[3]  = '{0, 3'b100, 32'h101, 32'h0,        32'h12349A78, 0, 32'h0000009A, 4'h0,    32'h0,        2};
        vecs[4]  = '{0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 4'h0,    32'h0,        2};
        vecs[5]  = '{0, 3'b000, 32'h100, 32'h0,        32'h0000007F, 0, 32'h0000007F, 4'h0,    32'h0,        2};
        vecs[6]  = '{0, 3'b101, 32'h100, 32'h0,        32'hFFFF8001, 0, 32'h00008001, 4'h0,    32'h0,        2};
        vecs[7]  = '{1, 3'b000, 32'h201, 32'h000000AB, 32'h0,        0, 32'h0,        4'b0010, 32'hABABABAB, 1};
        vecs[8]  = '{1, 3'b001, 32'h202, 32'h1234CDEF, 32'h0,        0, 32'h0,        4'b1100, 32'hCDEFCDEF, 1};
        vecs[9]  = '{1, 3'b010, 32'h204, 32'h11223344, 32'h0,        0, 32'h0,        4'b1111, 32'h11223344, 1};
        vecs[10] = '{0, 3'b010, 32'h102, 32'h0,        32'h0,        1, 32'h0,        4'h0,    32'h0,        0};
        vecs[11] = '{0, 3'b001, 32'h101, 32'h0,        32'h0,        1, 32'h0,        4'h0,    32'h0,        0};
        vecs[12] = '{1, 3'b010, 32'h203, 32'h55555555, 32'h0,        1, 32'h0,        4'h0,    32'h0,        0};
        vecs[13] = '{0, 3'b011, 32'h100, 32'h0,        32'h0,        1, 32'h0,        4'h0,    32'h0,        0};
        vecs[14] = '{1, 3'b100, 32'h100, 32'h0,        32'h0,        1, 32'h0,        4'h0,    32'h0,        0};

        #3;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 15; i++) run(i, vecs[i]);

        // Grant withheld for three cycles
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stall%0d_mem_req", k), {31'd0, mem_req}, 32'd1);
            chk($sformatf("stall%0d_addr", k), mem_addr, 32'h300);
            chk($sformatf("stall%0d_ready", k), {31'd0, req_ready}, 32'd0);
            chk($sformatf("stall%0d_busy", k), {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("stall_req_drop", {31'd0, mem_req}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("stall_rdata", rsp_rdata, 32'hCAFEF00D);
        @(negedge clk);

        // Reset while waiting for read data, then a stale rvalid
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h400;
        @(negedge clk);
        req_valid = 1'b0;
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("rw_in_wait", {31'd0, busy && !mem_req && !rsp_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rw_busy_async", {31'd0, busy}, 32'd0);
        chk("rw_addr_async", mem_addr, 32'd0);
        #1;
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rw%0d_no_rsp", k), {31'd0, rsp_valid}, 32'd0);
            chk($sformatf("rw%0d_ready", k), {31'd0, req_ready}, 32'd1);
            chk($sformatf("rw%0d_busy", k), {31'd0, busy}, 32'd0);
        end
        mem_rvalid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
